timer_disp_scan: RTL and testbench

- Multiplexed 4-digit seven-segment driver for the Basys3 timer; sits directly downstream of the clock divider.
- Consumes the divider's clk_display and clk_blinking levels as sampled enables. All logic runs on clk_sourecs, with no derived-clock flops.
- Scans BCD digits onto the anode/segment pins, with anti-ghost blanking, per-digit blink and optional leading-zero suppression.

---
 rtl/timer_pkg.sv | 25 ++
 rtl/bcd_to_seg7.sv | 28 ++
 rtl/timer_disp_scan.sv | 140 ++++++++++++++
 tb/tb_timer_disp_scan.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the Basys3 timer display path: the scan state
// encoding and active-low seven-segment glyphs, bit order {g,f,e,d,c,b,a}.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } scan_state_t;

  // A cleared bit lights that segment.
  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder. Codes 10-15 show a
// dash so a corrupted digit is visible rather than silently blank.
module bcd_to_seg7
  import timer_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Glyph lookup for one digit.
  always_comb begin
    // NOTE: every path assigns seg (the default arm covers 10-15), so no latch is inferred.
    unique case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/timer_disp_scan.sv
// Multiplexed seven-segment scanner for the Basys3 timer. The divider's
// clk_display level is edge-detected into a one-cycle scan_tick enable; every
// flop runs on clk_sourecs. Each digit is preceded by BLANK_CYCLES of all
// anodes off so the previous digit's segments never ghost onto the next one.
module timer_disp_scan
  import timer_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int BLANK_CYCLES = 16,
  parameter int LZ_SUPPRESS  = 0,
  parameter int DP_POS       = 2
) (
  input  logic                    clk_sourecs,
  input  logic                    rest,
  input  logic                    clk_display,
  input  logic                    clk_blinking,
  input  logic                    disp_en,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp
);

  localparam int PTR_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(BLANK_CYCLES + 1);

  localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(NUM_DIGITS - 1);
  localparam logic [PTR_W-1:0] DP_PTR     = PTR_W'(DP_POS);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  scan_state_t      state;
  logic [PTR_W-1:0] ptr;
  logic [CNT_W-1:0] blank_cnt;
  logic             disp_d;
  logic [3:0]       cur_val;

  logic                  scan_tick;
  logic [3:0]            ptr_digit;
  logic [NUM_DIGITS-1:0] an_sel;
  logic                  ptr_blink;
  logic [3:0]            show_val;
  logic [6:0]            dec_seg;
  logic                  blanked;
  logic                  lz_hit;
  logic [6:0]            drive_seg;
  logic                  drive_dp;

  // Same clock domain as the divider, so a plain edge detect is enough.
  assign scan_tick = clk_display & ~disp_d;

  // Select the pointed-to digit's BCD value, anode pattern and blink bit.
  always_comb begin
    ptr_digit = '0;
    an_sel    = '1;
    ptr_blink = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (ptr == PTR_W'(i)) begin
        ptr_digit = bcd_in[4*i +: 4];
        an_sel[i] = 1'b0;
        ptr_blink = blink_mask[i];
      end
    end
  end

  // On DRIVE entry the incoming digit is decoded directly so segments and
  // anode appear together; afterwards the latched value prevents tearing.
  assign show_val = (state == DRIVE) ? cur_val : ptr_digit;

  bcd_to_seg7 u_dec (
    .bcd (show_val),
    .seg (dec_seg)
  );

  // Blink and leading-zero blanking keep the anode driven, only the glyph goes dark.
  always_comb begin
    blanked   = ptr_blink & clk_blinking;
    lz_hit    = (LZ_SUPPRESS != 0) && (ptr == LAST_PTR) && (show_val == 4'd0);
    drive_seg = (blanked || lz_hit) ? SEG_OFF : dec_seg;
    drive_dp  = ~((ptr == DP_PTR) & ~blanked);
  end

  // Scan FSM with registered pin outputs; disable has priority over scan_tick.
  always_ff @(posedge clk_sourecs or negedge rest) begin
    if (!rest) begin
      state     <= IDLE;
      ptr       <= '0;
      blank_cnt <= '0;
      disp_d    <= 1'b0;
      cur_val   <= '0;
      an        <= '1;
      seg       <= SEG_OFF;
      dp        <= 1'b1;
    end else begin
      // NOTE: non-blocking throughout; the blank defaults below are overridden
      // later in this block only where a digit is driven.
      disp_d <= clk_display;
      an     <= '1;
      seg    <= SEG_OFF;
      dp     <= 1'b1;
      if (!disp_en) begin
        state     <= IDLE;
        ptr       <= '0;
        blank_cnt <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            state     <= BLANK;
            ptr       <= '0;
            blank_cnt <= '0;
          end
          BLANK: begin
            if (blank_cnt == BLANK_LAST) begin
              state   <= DRIVE;
              cur_val <= ptr_digit;
              an      <= an_sel;
              seg     <= drive_seg;
              dp      <= drive_dp;
            end else begin
              blank_cnt <= blank_cnt + 1'b1;
            end
          end
          DRIVE: begin
            if (scan_tick) begin
              state     <= BLANK;
              ptr       <= (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
              blank_cnt <= '0;
            end else begin
              an  <= an_sel;
              seg <= drive_seg;
              dp  <= drive_dp;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_timer_disp_scan.sv
// Bench for timer_disp_scan: two instances (leading-zero suppression off/on)
// share all inputs. A trace-level model predicts each pin value from the
// display rules: digit order, gap length, glyph per latched value, blink and
// decimal point.
module tb_timer_disp_scan;

  logic        clk_sourecs = 1'b0;
  logic        rest = 1'b0;
  logic        clk_display = 1'b0;
  logic        clk_blinking = 1'b0;
  logic        disp_en = 1'b0;
  logic [15:0] bcd_in = '0;
  logic [3:0]  blink_mask = '0;
  logic [3:0]  an0, an1;
  logic [6:0]  seg0, seg1;
  logic        dp0, dp1;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Inputs as seen by the DUTs at the most recent rising edge.
  logic [15:0] s_bcd;
  logic [3:0]  s_bm;
  logic        s_blk;
  logic        s_en;

  always #5 clk_sourecs = ~clk_sourecs;

  timer_disp_scan #(.BLANK_CYCLES(4)) dut (
    .clk_sourecs (clk_sourecs), .rest (rest), .clk_display (clk_display),
    .clk_blinking (clk_blinking), .disp_en (disp_en), .bcd_in (bcd_in),
    .blink_mask (blink_mask), .an (an0), .seg (seg0), .dp (dp0)
  );

  timer_disp_scan #(.BLANK_CYCLES(4), .LZ_SUPPRESS(1)) dut_lz (
    .clk_sourecs (clk_sourecs), .rest (rest), .clk_display (clk_display),
    .clk_blinking (clk_blinking), .disp_en (disp_en), .bcd_in (bcd_in),
    .blink_mask (blink_mask), .an (an1), .seg (seg1), .dp (dp1)
  );

  typedef struct {
    logic       an_ok;
    logic       new_run;
    logic       seq_ok;
    int         digit;
    int         want_digit;
    int         gap;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  // Model state per instance.
  logic [3:0] m_prev_an [2];
  int         m_off     [2];
  int         m_next    [2];
  int         m_val     [2];
  bit         m_seen    [2];

  // Active-low pattern from the list of lit segment letters.
  function automatic logic [6:0] lit(input string s);
    logic [6:0] r;
    int k;
    r = 7'h7F;
    for (int i = 0; i < s.len(); i++) begin
      k = int'(s.getc(i)) - 97;
      r[k] = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [6:0] glyph(input int v);
    case (v)
      0: return lit("abcdef");
      1: return lit("bc");
      2: return lit("abdeg");
      3: return lit("abcdg");
      4: return lit("bcfg");
      5: return lit("acdfg");
      6: return lit("acdefg");
      7: return lit("abc");
      8: return lit("abcdefg");
      9: return lit("abcdfg");
      default: return lit("g");
    endcase
  endfunction

  function automatic void model_reset(input int id);
    m_prev_an[id] = 4'hF;
    m_off[id]     = 0;
    m_next[id]    = 0;
    m_val[id]     = 0;
    m_seen[id]    = 1'b0;
  endfunction

  // Predict this cycle's pins given the anode pattern the DUT chose.
  function automatic exp_t model_eval(input int id, input logic [3:0] a);
    exp_t e;
    int   d;
    logic blk;
    e.new_run = 1'b0; e.seq_ok = 1'b1; e.digit = -1; e.want_digit = -1;
    e.gap = m_off[id]; e.seg = 7'h7F; e.dp = 1'b1;
    e.an_ok = (a === 4'hF) || ($countones(~a) == 1);
    if (!s_en) begin
      e.an_ok = (a === 4'hF);
      model_reset(id);
      return e;
    end
    if (a === 4'hF) begin
      m_off[id]++;
      m_prev_an[id] = a;
      return e;
    end
    d = 0;
    for (int i = 0; i < 4; i++) if (a[i] === 1'b0) d = i;
    e.digit = d;
    if (a !== m_prev_an[id]) begin
      e.new_run    = 1'b1;
      e.want_digit = m_next[id];
      e.seq_ok     = (d == m_next[id]) && (!m_seen[id] || m_off[id] == 4);
      m_val[id]    = int'(s_bcd[4*d +: 4]);
      m_next[id]   = (d + 1) % 4;
      m_seen[id]   = 1'b1;
      m_off[id]    = 0;
    end
    blk   = s_bm[d] && s_blk;
    e.seg = (blk || (id == 1 && d == 3 && m_val[id] == 0)) ? 7'h7F : glyph(m_val[id]);
    e.dp  = (d == 2 && !blk) ? 1'b0 : 1'b1;
    m_prev_an[id] = a;
    return e;
  endfunction

  // One clock: snapshot inputs at the edge, settle, then advance clk_display.
  task automatic tick();
    @(posedge clk_sourecs);
    s_bcd = bcd_in; s_bm = blink_mask; s_blk = clk_blinking; s_en = disp_en;
    #1;
    cyc++;
    clk_display = ((cyc % 64) >= 32);
  endtask

  task automatic test_reset();
    rest = 1'b0; disp_en = 1'b0;
    repeat (5) tick();
    checks += 2;
    if ({an0, seg0, dp0} !== {4'hF, 7'h7F, 1'b1}) begin
      errors++; $display("FAIL reset_dut0 an=%b seg=%h dp=%b required 1111/7f/1", an0, seg0, dp0);
    end
    if ({an1, seg1, dp1} !== {4'hF, 7'h7F, 1'b1}) begin
      errors++; $display("FAIL reset_dut1 an=%b seg=%h dp=%b required 1111/7f/1", an1, seg1, dp1);
    end
    rest = 1'b1;
    for (int n = 0; n < 10; n++) begin
      tick();
      checks++;
      if ({an0, seg0, dp0, an1, seg1, dp1} !== {4'hF, 7'h7F, 1'b1, 4'hF, 7'h7F, 1'b1}) begin
        errors++; $display("FAIL reset_idle cyc=%0d an=%b/%b seg=%h/%h required blank", cyc, an0, an1, seg0, seg1);
      end
    end
    model_reset(0); model_reset(1);
  endtask

  task automatic test_scan_order();
    exp_t e; logic [3:0] a; logic [6:0] sg; logic p;
    int runs [2];
    logic [6:0] got [4];
    logic [6:0] want [4];
    want = '{7'h19, 7'h30, 7'h24, 7'h79};
    got  = '{7'hxx, 7'hxx, 7'hxx, 7'hxx};
    runs = '{0, 0};
    bcd_in = 16'h1234; blink_mask = 4'b0000; clk_blinking = 1'b0; disp_en = 1'b1;
    for (int n = 0; n < 600; n++) begin
      tick();
      for (int id = 0; id < 2; id++) begin
        a = id ? an1 : an0; sg = id ? seg1 : seg0; p = id ? dp1 : dp0;
        e = model_eval(id, a);
        if (e.new_run) runs[id]++;
        if (e.new_run && id == 0) got[e.digit] = sg;
        checks += 4;
        if (!e.an_ok) begin errors++; $display("FAIL scan_anode dut%0d cyc=%0d an=%b required one low or 1111", id, cyc, a); end
        if (!e.seq_ok) begin errors++; $display("FAIL scan_order dut%0d cyc=%0d digit=%0d gap=%0d required digit %0d gap 4", id, cyc, e.digit, e.gap, e.want_digit); end
        if (sg !== e.seg) begin errors++; $display("FAIL scan_seg dut%0d cyc=%0d an=%b seg=%h required %h", id, cyc, a, sg, e.seg); end
        if (p !== e.dp) begin errors++; $display("FAIL scan_dp dut%0d cyc=%0d an=%b dp=%b required %b", id, cyc, a, p, e.dp); end
      end
    end
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (got[d] !== want[d]) begin errors++; $display("FAIL scan_glyph digit%0d seg=%h required %h", d, got[d], want[d]); end
    end
    checks++;
    if (runs[0] < 8 || runs[1] < 8) begin errors++; $display("FAIL scan_runs got %0d/%0d digit runs required at least 8", runs[0], runs[1]); end
  endtask

  task automatic test_blink();
    exp_t e; logic [3:0] a; logic [6:0] sg; logic p;
    int runs [2];
    bit dark_lit;
    runs = '{0, 0}; dark_lit = 1'b0;
    blink_mask = 4'b0011; clk_blinking = 1'b1;
    for (int n = 0; n < 800; n++) begin
      if (n == 300) clk_blinking = 1'b0;
      if (n >= 400) begin
        if ($urandom_range(11, 0) == 0) clk_blinking = ~clk_blinking;
        if ($urandom_range(63, 0) == 0) blink_mask = 4'($urandom);
      end
      tick();
      if (n < 300 && (an0 === 4'b1110 || an0 === 4'b1101) && seg0 === 7'h7F) dark_lit = 1'b1;
      for (int id = 0; id < 2; id++) begin
        a = id ? an1 : an0; sg = id ? seg1 : seg0; p = id ? dp1 : dp0;
        e = model_eval(id, a);
        if (e.new_run) runs[id]++;
        checks += 4;
        if (!e.an_ok) begin errors++; $display("FAIL blink_anode dut%0d cyc=%0d an=%b required one low or 1111", id, cyc, a); end
        if (!e.seq_ok) begin errors++; $display("FAIL blink_order dut%0d cyc=%0d digit=%0d gap=%0d required digit %0d gap 4", id, cyc, e.digit, e.gap, e.want_digit); end
        if (sg !== e.seg) begin errors++; $display("FAIL blink_seg dut%0d cyc=%0d an=%b seg=%h required %h", id, cyc, a, sg, e.seg); end
        if (p !== e.dp) begin errors++; $display("FAIL blink_dp dut%0d cyc=%0d an=%b dp=%b required %b", id, cyc, a, p, e.dp); end
      end
    end
    checks += 2;
    if (!dark_lit) begin errors++; $display("FAIL blink_dark saw_dark_driven=%0d required 1", dark_lit); end
    if (runs[0] < 10) begin errors++; $display("FAIL blink_runs got %0d digit runs required at least 10", runs[0]); end
    blink_mask = 4'b0000; clk_blinking = 1'b0;
  endtask

  task automatic test_lz();
    exp_t e; logic [3:0] a; logic [6:0] sg; logic p;
    logic [6:0] last3, last2;
    for (int ph = 0; ph < 2; ph++) begin
      bcd_in = (ph == 0) ? 16'h0905 : 16'hA000;
      last3 = 7'hxx; last2 = 7'hxx;
      for (int n = 0; n < 320; n++) begin
        tick();
        if (an1 === 4'b0111) last3 = seg1;
        if (an1 === 4'b1011) last2 = seg1;
        for (int id = 0; id < 2; id++) begin
          a = id ? an1 : an0; sg = id ? seg1 : seg0; p = id ? dp1 : dp0;
          e = model_eval(id, a);
          checks += 4;
          if (!e.an_ok) begin errors++; $display("FAIL lz_anode dut%0d cyc=%0d an=%b required one low or 1111", id, cyc, a); end
          if (!e.seq_ok) begin errors++; $display("FAIL lz_order dut%0d cyc=%0d digit=%0d gap=%0d required digit %0d gap 4", id, cyc, e.digit, e.gap, e.want_digit); end
          if (sg !== e.seg) begin errors++; $display("FAIL lz_seg dut%0d cyc=%0d an=%b seg=%h required %h", id, cyc, a, sg, e.seg); end
          if (p !== e.dp) begin errors++; $display("FAIL lz_dp dut%0d cyc=%0d an=%b dp=%b required %b", id, cyc, a, p, e.dp); end
        end
      end
      checks++;
      if (last3 !== ((ph == 0) ? 7'h7F : 7'h3F)) begin
        errors++; $display("FAIL lz_digit3 phase%0d seg=%h required %h", ph, last3, (ph == 0) ? 7'h7F : 7'h3F);
      end
      if (ph == 0) begin
        checks++;
        if (last2 !== 7'h10) begin errors++; $display("FAIL lz_digit2 seg=%h required 10", last2); end
      end
    end
  endtask

  task automatic test_tearing();
    exp_t e; logic [3:0] a; logic [6:0] sg; logic p;
    int phase, in_run;
    phase = 0; in_run = 0;
    bcd_in = 16'h0000;
    for (int n = 0; n < 800 && phase < 3; n++) begin
      tick();
      for (int id = 0; id < 2; id++) begin
        a = id ? an1 : an0; sg = id ? seg1 : seg0; p = id ? dp1 : dp0;
        e = model_eval(id, a);
        checks += 4;
        if (!e.an_ok) begin errors++; $display("FAIL tear_anode dut%0d cyc=%0d an=%b required one low or 1111", id, cyc, a); end
        if (!e.seq_ok) begin errors++; $display("FAIL tear_order dut%0d cyc=%0d digit=%0d gap=%0d required digit %0d gap 4", id, cyc, e.digit, e.gap, e.want_digit); end
        if (sg !== e.seg) begin errors++; $display("FAIL tear_seg dut%0d cyc=%0d an=%b seg=%h required %h", id, cyc, a, sg, e.seg); end
        if (p !== e.dp) begin errors++; $display("FAIL tear_dp dut%0d cyc=%0d an=%b dp=%b required %b", id, cyc, a, p, e.dp); end
        if (id == 0) begin
          if (phase == 0) begin
            if (e.new_run && e.digit == 1) in_run = 1;
            else if (in_run > 0 && an0 === 4'b1101) in_run++;
            if (in_run == 3) begin bcd_in = 16'h8888; phase = 1; end
          end else if (phase == 1) begin
            if (e.new_run && e.digit == 1) begin
              checks++;
              if (seg0 !== 7'h00) begin errors++; $display("FAIL tear_new seg=%h required 00", seg0); end
              phase = 3;
            end else if (an0 === 4'b1101) begin
              checks++;
              if (seg0 !== 7'h40) begin errors++; $display("FAIL tear_hold cyc=%0d seg=%h required 40", cyc, seg0); end
            end
          end
        end
      end
    end
    checks++;
    if (phase != 3) begin errors++; $display("FAIL tear_timeout phase=%0d required 3", phase); end
  endtask

  task automatic test_disable_and_reset();
    exp_t e; logic [3:0] a; logic [6:0] sg; logic p;
    int n;
    // Run to digit 2, then drop disp_en.
    n = 0;
    while (an0 !== 4'b1011 && n < 400) begin
      tick(); n++;
      for (int id = 0; id < 2; id++) begin
        a = id ? an1 : an0; sg = id ? seg1 : seg0; p = id ? dp1 : dp0;
        e = model_eval(id, a);
        checks += 2;
        if (!e.an_ok || !e.seq_ok) begin errors++; $display("FAIL dis_scan dut%0d cyc=%0d an=%b gap=%0d", id, cyc, a, e.gap); end
        if (sg !== e.seg || p !== e.dp) begin errors++; $display("FAIL dis_pins dut%0d cyc=%0d seg=%h dp=%b required %h/%b", id, cyc, sg, p, e.seg, e.dp); end
      end
    end
    checks++;
    if (an0 !== 4'b1011) begin errors++; $display("FAIL dis_reach an=%b required 1011", an0); end
    disp_en = 1'b0;
    tick();
    void'(model_eval(0, an0)); void'(model_eval(1, an1));
    checks++;
    if ({an0, seg0, dp0, an1} !== {4'hF, 7'h7F, 1'b1, 4'hF}) begin
      errors++; $display("FAIL dis_blank an=%b/%b seg=%h dp=%b required 1111/7f/1", an0, an1, seg0, dp0);
    end
    repeat (3) begin tick(); void'(model_eval(0, an0)); void'(model_eval(1, an1)); end
    // Re-enable: one idle edge plus four blank cycles, then digit 0.
    disp_en = 1'b1;
    n = 0;
    do begin
      tick(); n++;
      void'(model_eval(0, an0)); void'(model_eval(1, an1));
    end while (an0 === 4'hF && n < 20);
    checks += 2;
    if (n != 5) begin errors++; $display("FAIL reen_delay cycles=%0d required 5", n); end
    if (an0 !== 4'b1110) begin errors++; $display("FAIL reen_digit an=%b required 1110", an0); end
    // Asynchronous reset while a digit is driven.
    tick(); tick();
    #2 rest = 1'b0;
    #1;
    checks++;
    if ({an0, seg0, dp0, an1, seg1, dp1} !== {4'hF, 7'h7F, 1'b1, 4'hF, 7'h7F, 1'b1}) begin
      errors++; $display("FAIL async_reset an=%b/%b seg=%h/%h dp=%b/%b required blank", an0, an1, seg0, seg1, dp0, dp1);
    end
    tick();
    rest = 1'b1;
    model_reset(0); model_reset(1);
  endtask

  task automatic test_random();
    exp_t e; logic [3:0] a; logic [6:0] sg; logic p;
    int runs [2];
    runs = '{0, 0};
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(39, 0) == 0) bcd_in = 16'($urandom);
      if ($urandom_range(29, 0) == 0) blink_mask = 4'($urandom);
      if ($urandom_range(11, 0) == 0) clk_blinking = ~clk_blinking;
      if (disp_en && $urandom_range(499, 0) == 0) disp_en = 1'b0;
      else if (!disp_en && $urandom_range(7, 0) == 0) disp_en = 1'b1;
      tick();
      for (int id = 0; id < 2; id++) begin
        a = id ? an1 : an0; sg = id ? seg1 : seg0; p = id ? dp1 : dp0;
        e = model_eval(id, a);
        if (e.new_run) runs[id]++;
        checks += 4;
        if (!e.an_ok) begin errors++; $display("FAIL rand_anode dut%0d cyc=%0d an=%b required one low or 1111", id, cyc, a); end
        if (!e.seq_ok) begin errors++; $display("FAIL rand_order dut%0d cyc=%0d digit=%0d gap=%0d required digit %0d gap 4", id, cyc, e.digit, e.gap, e.want_digit); end
        if (sg !== e.seg) begin errors++; $display("FAIL rand_seg dut%0d cyc=%0d an=%b seg=%h required %h", id, cyc, a, sg, e.seg); end
        if (p !== e.dp) begin errors++; $display("FAIL rand_dp dut%0d cyc=%0d an=%b dp=%b required %b", id, cyc, a, p, e.dp); end
      end
    end
    checks++;
    if (runs[0] < 20 || runs[1] < 20) begin errors++; $display("FAIL rand_runs got %0d/%0d digit runs required at least 20", runs[0], runs[1]); end
  endtask

  initial begin
    model_reset(0); model_reset(1);
    test_reset();
    test_scan_order();
    test_blink();
    test_lz();
    test_tearing();
    test_disable_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
